// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores fill a FIFO and STATUS is read combinationally.
// A push into an idle, empty unit starts the start bit one cycle later. The CPU never sees backpressure; a push into a full FIFO sets a sticky overflow flag.

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop_rdy && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mmio_uart_tx #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CLK_FREQ_HZ = 50_000_000,
  parameter int                    BAUD_RATE   = 115_200,
  parameter int                    FIFO_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE   = 32'h1000_0000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_mmio_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_mmio_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_mmio_wr_data,
  input  logic                  i_mmio_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_mmio_rd_addr,
  output logic [DATA_WIDTH-1:0] o_mmio_rd_data,
  output logic                  o_mmio_hit,
  output logic                  o_uart_tx
);
  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNTW     = $clog2(BAUD_DIV);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            tx_q, tx_nxt;
  logic            pop;
  logic            bit_end;

  logic            wr_hit;
  logic [1:0]      wr_sel;
  logic [1:0]      rd_sel;
  logic            push_req;
  logic            ovf_set;
  logic            ovf_clr;
  logic            overflow;
  logic [7:0]      head_dat;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [DATA_WIDTH-1:0] status;
  logic            unused_bits;

  // The window is 16-byte aligned, so decoding compares everything above bit 3.
  assign wr_hit   = i_mmio_wr_en && (i_mmio_wr_addr[ADDR_WIDTH-1:4] == UART_BASE[ADDR_WIDTH-1:4]);
  assign wr_sel   = i_mmio_wr_addr[3:2];
  assign rd_sel   = i_mmio_rd_addr[3:2];
  assign push_req = wr_hit && (wr_sel == 2'd0);
  assign ovf_clr  = wr_hit && (wr_sel == 2'd2) && i_mmio_wr_data[0];
  assign ovf_set  = push_req && full && !pop;

  assign unused_bits = ^{i_mmio_wr_data[DATA_WIDTH-1:8], i_mmio_wr_addr[1:0], i_mmio_rd_addr[1:0]};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_rst_n),
    .push_vld (push_req),
    .push_dat (i_mmio_wr_data[7:0]),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // A set in the same cycle as a clear wins, so a byte dropped in that cycle is still reported.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)  overflow <= 1'b0;
    else if (ovf_set)  overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

  assign bit_end = (cnt == CNTW'(BAUD_DIV - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      tx_q  <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head_dat;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          tx_nxt    = shift[0];
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
            idx_nxt   = idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = head_dat;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_uart_tx = tx_q;

  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[2]       = (state != IDLE);
    status[3]       = overflow;
    status[8 +: CW] = count;
  end

  assign o_mmio_hit     = i_mmio_rd_en && (i_mmio_rd_addr[ADDR_WIDTH-1:4] == UART_BASE[ADDR_WIDTH-1:4]);
  assign o_mmio_rd_data = (o_mmio_hit && (rd_sel == 2'd1)) ? status : '0;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx at BAUD_DIV=4 and FIFO_DEPTH=4; a line decoder rebuilds the transmitted frames.
module tb_mmio_uart_tx;
  localparam int          BD    = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        hit;
  logic        tx;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [8:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];

  mmio_uart_tx #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .CLK_FREQ_HZ (40),
    .BAUD_RATE   (10),
    .FIFO_DEPTH  (DEPTH),
    .UART_BASE   (BASE)
  ) dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_mmio_wr_en   (wr_en),
    .i_mmio_wr_addr (wr_addr),
    .i_mmio_wr_data (wr_data),
    .i_mmio_rd_en   (rd_en),
    .i_mmio_rd_addr (rd_addr),
    .o_mmio_rd_data (rd_data),
    .o_mmio_hit     (hit),
    .o_uart_tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit in its middle, records {stop, data} and the start cycle.
  initial begin
    logic [8:0] v;
    int t;
    forever begin
      @(posedge clk); #1;
      if (rst_n && tx === 1'b0) begin
        t = cyc;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
          repeat (BD) begin @(posedge clk); #1; end
          v[i] = tx;
        end
        repeat (BD) begin @(posedge clk); #1; end
        v[8] = tx;
        @(posedge clk); #1;
        st_q.push_back(t);
        rx_q.push_back(v);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(int cnt, bit busy, bit ovf);
    logic [31:0] s;
    s = '0;
    s[0] = (cnt == DEPTH);
    s[1] = (cnt == 0);
    s[2] = busy;
    s[3] = ovf;
    s[15:8] = 8'(cnt);
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic h);
    rd_en = 1'b1; rd_addr = a;
    #1;
    v = rd_data; h = hit;
    rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    logic h;
    int n;
    n = 0;
    rd(BASE + 4, v, h);
    while (((v & 32'h6) != 32'h2) && n < 2000) begin
      step();
      rd(BASE + 4, v, h);
      n++;
    end
    checks++;
    if (n >= 2000) $display("FAIL idle_timeout: status %h after %0d cycles, want busy=0 empty=1", v, n);
    else passes++;
    repeat (2) step();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic h;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passes++;
    rd_addr = BASE + 4; rd_en = 1'b0; #1;
    checks++; if (hit !== 1'b0) $display("FAIL reset_hit_idle: got %b want 0", hit); else passes++;
    checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_idle: got %h want 0", rd_data); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(BASE + 4, v, h);
    checks++; if (v !== 32'h2) $display("FAIL reset_status: got %h want 00000002", v); else passes++;
    checks++; if (h !== 1'b1) $display("FAIL reset_hit: got %b want 1", h); else passes++;
  endtask

  task automatic test_map();
    logic [31:0] v;
    logic h;
    rd(BASE + 0, v, h);
    checks++; if (v !== 32'h0 || h !== 1'b1) $display("FAIL map_txdata_rd: got %h/%b want 0/1", v, h); else passes++;
    rd(BASE + 8, v, h);
    checks++; if (v !== 32'h0 || h !== 1'b1) $display("FAIL map_ctrl_rd: got %h/%b want 0/1", v, h); else passes++;
    rd(BASE + 12, v, h);
    checks++; if (v !== 32'h0 || h !== 1'b1) $display("FAIL map_rsvd_rd: got %h/%b want 0/1", v, h); else passes++;
    rd(BASE + 7, v, h);
    checks++; if (v !== 32'h2) $display("FAIL map_status_lowbits: got %h want 00000002", v); else passes++;
    rd(BASE + 16, v, h);
    checks++; if (v !== 32'h0 || h !== 1'b0) $display("FAIL map_above_window: got %h/%b want 0/0", v, h); else passes++;
    rd(BASE - 4, v, h);
    checks++; if (v !== 32'h0 || h !== 1'b0) $display("FAIL map_below_window: got %h/%b want 0/0", v, h); else passes++;
    wr(BASE + 16, 32'h41);
    wr(BASE + 4, 32'hFFFF_FFFF);
    wr(BASE + 12, 32'h42);
    wr(BASE - 16, 32'h43);
    repeat (3) step();
    rd(BASE + 4, v, h);
    checks++; if (v !== 32'h2) $display("FAIL map_ignored_writes: status %h want 00000002", v); else passes++;
    checks++; if (tx !== 1'b1) $display("FAIL map_line_idle: got %b want 1", tx); else passes++;
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    logic h;
    logic [9:0] frame;
    int errs;
    rx_q.delete(); st_q.delete();
    frame = {1'b1, 8'hA5, 1'b0};
    wr(BASE, {$urandom} << 8 | 32'hA5);
    checks++; if (tx !== 1'b1) $display("FAIL frame_push_edge_tx: got %b want 1", tx); else passes++;
    errs = 0;
    for (int k = 1; k <= 10 * BD; k++) begin
      step();
      if (tx !== frame[(k - 1) / BD]) errs++;
      if (k == 1) begin
        rd(BASE + 4, v, h);
        checks++; if (v !== exp_status(0, 1, 0)) $display("FAIL frame_busy_status: got %h want %h", v, exp_status(0, 1, 0)); else passes++;
      end
    end
    checks++; if (errs != 0) $display("FAIL frame_waveform: %0d bad cycles, want 0", errs); else passes++;
    step();
    rd(BASE + 4, v, h);
    checks++; if (v !== 32'h2) $display("FAIL frame_done_status: got %h want 00000002", v); else passes++;
    checks++; if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 8'hA5}) $display("FAIL frame_decode: got %0d frames first %h want 1 frame 1a5", rx_q.size(), rx_q.size() ? rx_q[0] : 9'h0); else passes++;
  endtask

  task automatic test_back_to_back();
    rx_q.delete(); st_q.delete();
    wr(BASE, 32'h55);
    wr(BASE, 32'h0F);
    wait_idle();
    checks++; if (rx_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", rx_q.size()); else passes++;
    if (rx_q.size() == 2) begin
      checks++; if (rx_q[0] !== 9'h155) $display("FAIL b2b_byte0: got %h want 155", rx_q[0]); else passes++;
      checks++; if (rx_q[1] !== 9'h10F) $display("FAIL b2b_byte1: got %h want 10f", rx_q[1]); else passes++;
      checks++; if (st_q[1] - st_q[0] != 10 * BD) $display("FAIL b2b_gap: got %0d want %0d", st_q[1] - st_q[0], 10 * BD); else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic h;
    logic [7:0] b[6];
    rx_q.delete(); st_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    wr(BASE, {24'h0, b[0]});
    step(); step();
    for (int i = 1; i <= 4; i++) wr(BASE, {24'h0, b[i]});
    rd(BASE + 4, v, h);
    checks++; if (v !== exp_status(4, 1, 0)) $display("FAIL ovf_full_status: got %h want %h", v, exp_status(4, 1, 0)); else passes++;
    wr(BASE, {24'h0, b[5]});
    rd(BASE + 4, v, h);
    checks++; if (v !== exp_status(4, 1, 1)) $display("FAIL ovf_set_status: got %h want %h", v, exp_status(4, 1, 1)); else passes++;
    wr(BASE + 8, 32'h1);
    rd(BASE + 4, v, h);
    checks++; if (v !== exp_status(4, 1, 0)) $display("FAIL ovf_clear_status: got %h want %h", v, exp_status(4, 1, 0)); else passes++;
    wait_idle();
    checks++; if (rx_q.size() != 5) $display("FAIL ovf_line_count: got %0d want 5", rx_q.size()); else passes++;
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== {1'b1, b[i]}) $display("FAIL ovf_line_byte%0d: got %h want %h", i, rx_q[i], {1'b1, b[i]}); else passes++;
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    logic h;
    logic [7:0] b[6];
    rx_q.delete(); st_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    // Byte 0 pops one edge after its push; its stop bit ends 40 edges after that pop.
    for (int i = 0; i < 5; i++) wr(BASE, {24'h0, b[i]});
    rd(BASE + 4, v, h);
    checks++; if (v !== exp_status(4, 1, 0)) $display("FAIL fullpop_pre_status: got %h want %h", v, exp_status(4, 1, 0)); else passes++;
    repeat (10 * BD - 4) step();
    wr(BASE, {24'h0, b[5]});
    checks++; if (tx !== 1'b0) $display("FAIL fullpop_restart_tx: got %b want 0", tx); else passes++;
    rd(BASE + 4, v, h);
    checks++; if (v !== exp_status(4, 1, 0)) $display("FAIL fullpop_post_status: got %h want %h", v, exp_status(4, 1, 0)); else passes++;
    wait_idle();
    checks++; if (rx_q.size() != 6) $display("FAIL fullpop_line_count: got %0d want 6", rx_q.size()); else passes++;
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== {1'b1, b[i]}) $display("FAIL fullpop_byte%0d: got %h want %h", i, rx_q[i], {1'b1, b[i]}); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic h;
    logic [7:0] d;
    int len;
    int acc;
    bit ovf;
    for (int it = 0; it < 6; it++) begin
      rx_q.delete(); st_q.delete(); exp_q.delete();
      len = $urandom_range(1, 7);
      // A burst into an idle unit: the first byte is popped at once, the rest fill the FIFO.
      acc = (len < DEPTH + 1) ? len : DEPTH + 1;
      ovf = (len > DEPTH + 1);
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        if (i < acc) exp_q.push_back(d);
        wr(BASE | 32'($urandom_range(0, 3)), ($urandom & 32'hFFFF_FF00) | {24'h0, d});
      end
      step();
      rd(BASE + 4, v, h);
      checks++; if (v !== exp_status(acc - 1, 1, ovf)) $display("FAIL rand%0d_status: len %0d got %h want %h", it, len, v, exp_status(acc - 1, 1, ovf)); else passes++;
      if (ovf) begin
        wr(BASE + 8, $urandom & 32'hFFFF_FFFE);
        rd(BASE + 4, v, h);
        checks++; if (v[3] !== 1'b1) $display("FAIL rand%0d_ctrl0_keeps: got %b want 1", it, v[3]); else passes++;
        wr(BASE + 8 + 32'($urandom_range(0, 3)), $urandom | 32'h1);
        rd(BASE + 4, v, h);
        checks++; if (v[3] !== 1'b0) $display("FAIL rand%0d_ctrl1_clears: got %b want 0", it, v[3]); else passes++;
      end
      wait_idle();
      checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", it, rx_q.size(), exp_q.size()); else passes++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, rx_q[i], {1'b1, exp_q[i]}); else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic h;
    int lows;
    wr(BASE, 32'h00);
    wr(BASE, 32'h3C);
    wr(BASE, 32'hC3);
    repeat (15) step();
    #3;
    checks++; if (tx !== 1'b0) $display("FAIL rstmid_pre_tx: got %b want 0", tx); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL rstmid_async_tx: got %b want 1", tx); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(BASE + 4, v, h);
    checks++; if (v !== 32'h2) $display("FAIL rstmid_status: got %h want 00000002", v); else passes++;
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) $display("FAIL rstmid_line_quiet: %0d low cycles, want 0", lows); else passes++;
    rx_q.delete(); st_q.delete();
  endtask

  initial begin
    test_reset();
    test_map();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
